// File: rtl/rr_mux_4_1.sv
// rr_mux_4_1: four-source round-robin arbiter feeding a single registered
// output stage with valid/ready handshakes. The last-grant pointer rotates
// priority so that a continuously valid source is served within four transfers.
module rr_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_sel_q,   out_sel_d;
  logic [1:0]       ptr_q,       ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [WIDTH-1:0] d_arr [4];

  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;

  // Output stage can accept a new item when empty or when it drains this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Priority search starting just after the last granted source.
  always_comb begin
    logic [1:0] cand;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!grant_vld && in_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One-hot ready to the granted source; nothing accepted during reset.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load_en && grant_vld) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next state of the output register and the last-grant pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = d_arr[grant_idx];
        out_sel_d   = grant_idx;
        ptr_d       = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State register; ptr resets to 3 so input 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr_q       <= 2'd3;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/rr_mux_4_1.md
RR_MUX_4_1 -- requirements
Module: rr_mux_4_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the width of each data path.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Ports d0, d1, d2, d3  input  WIDTH each  source data for inputs 0-3.
REQ-006 Port in_valid  input  4  bit i high: source i presents valid data on di.
REQ-007 Port in_ready  output  4  bit i high: source i's data is taken this cycle.
REQ-008 Port out_valid  output  1  out_data and out_sel hold a valid item.
REQ-009 Port out_data  output  WIDTH  registered selected data.
REQ-010 Port out_sel  output  2  index of the source that produced out_data.
REQ-011 Port out_ready  input  1  downstream accepts the item this cycle.

Function
REQ-012 The output register SHALL be loadable (load_en) when out_valid is 0 or out_ready is 1.
REQ-013 A source transfer SHALL occur on a cycle where in_valid[i] and in_ready[i] are both 1.
REQ-014 A downstream transfer SHALL occur on a cycle where out_valid and out_ready are both 1.
REQ-015 The block SHALL keep a 2-bit last-grant pointer ptr; search order is ptr+1, ptr+2, ptr+3, ptr+4, all mod 4.
REQ-016 The grant SHALL be the first index in search order with in_valid set; no valid input means no grant.
REQ-017 in_ready SHALL be one-hot or zero: in_ready[g]=1 only for granted g and only when load_en=1; combinational from in_valid, ptr, out_valid, out_ready.
REQ-018 in_ready[i] SHALL NOT depend on in_valid[j] of a lower-priority input, and SHALL be 0 for every input when load_en=0.
REQ-019 On a source transfer from g: next cycle out_valid=1, out_data=dg as sampled, out_sel=g, ptr=g (latency 1 cycle).
REQ-020 When load_en=1 and no input is valid: next cycle out_valid=0; out_data, out_sel, ptr unchanged.
REQ-021 When load_en=0 (out_valid=1, out_ready=0): out_valid, out_data, out_sel, ptr SHALL hold unchanged.
REQ-022 A downstream transfer and a source transfer in the same cycle SHALL both complete; sustained throughput 1 item/cycle.
REQ-023 ptr wrap-around: g=3 makes search order 0,1,2,3.
REQ-024 A source whose in_valid is held continuously SHALL be granted within 4 source transfers (starvation-free).
REQ-025 out_data SHALL be driven only from the register, never combinationally from d0-d3.
REQ-026 Data selection SHALL be an array-indexed 4:1 select on the granted index.

Reset
REQ-027 On rst=1 at a clock edge: out_valid=0, out_data=0, out_sel=0, ptr=3 (input 0 first priority).
REQ-028 While rst=1, in_ready SHALL be all 0; no source transfer is accepted.
REQ-029 rst SHALL override any in-flight item: a held unaccepted output is discarded.
REQ-030 rst SHALL take priority over simultaneous source/downstream transfers in the same cycle.

Verification
REQ-031 Reset: rst=1 for 2 cycles, all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0; first cycle after release in_ready=0001.
REQ-032 Fairness: in_valid=1111, d0..d3=1,2,3,4, out_ready=1 from reset -> out_sel 0,1,2,3,0 and out_data 1,2,3,4,1 on consecutive cycles, out_valid held 1.
REQ-033 Single source: only in_valid[2]=1, d2 increments each cycle 5,6,7, out_ready=1 -> in_ready=0100 every cycle, out_data 5,6,7 one cycle later, out_sel=2.
REQ-034 Backpressure: out_valid=1, out_data=9, out_ready=0 for 3 cycles, in_valid=1111 -> in_ready=0000 and out_data=9 held all 3 cycles; out_ready=1 -> next source granted same cycle.
REQ-035 Wrap: ptr=3 after grant to input 3, then in_valid=1010 -> grant input 1 (in_ready=0010), then input 3 next.
REQ-036 Mid-operation reset: with in_valid=1111 streaming, assert rst one cycle -> out_valid=0 next cycle, then grants restart at input 0.
